// File: rtl/addr_gen_stride_if.sv
// Control and address bus for addr_gen_stride: stepping controls in, BRAM address and
// sweep-boundary flags out.
interface addr_gen_stride_if #(
  parameter int COUNT_WIDTH = 13,
  parameter int BYTE_SHIFT  = 2
);
  logic                          en;
  logic                          mode;
  logic                          start;
  logic [COUNT_WIDTH-1:0]        count_max;
  logic [COUNT_WIDTH-1:0]        stride;
  logic [COUNT_WIDTH+BYTE_SHIFT-1:0] address;
  logic                          valid;
  logic                          wrap;
  logic                          done;

  modport master (
    output en, mode, start, count_max, stride,
    input  address, valid, wrap, done
  );

  modport slave (
    input  en, mode, start, count_max, stride,
    output address, valid, wrap, done
  );
endinterface

// File: rtl/addr_gen_stride.sv
// Strided BRAM byte-address generator with continuous and one-shot sweep modes.
// Define ADDR_GEN_STRIDE_EN for a programmable stride; otherwise the step is fixed at 1.
module addr_gen_stride #(
  parameter int COUNT_WIDTH = 13,
  parameter int BYTE_SHIFT  = 2
) (
  input logic              clk,
  input logic              sclr,
  addr_gen_stride_if.slave bus
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                 state_r;
  logic [COUNT_WIDTH-1:0] count_r;
  logic [COUNT_WIDTH-1:0] max_r;
  logic                   mode_r;
  logic                   valid_r;
  logic                   wrap_r;
  logic                   done_r;
  logic [COUNT_WIDTH:0]   nxt_s;
  logic                   terminal_s;
  logic                   load_cfg_s;

`ifdef ADDR_GEN_STRIDE_EN
  logic [COUNT_WIDTH-1:0] stride_r;

  // A zero stride would never advance, so it is promoted to 1.
  function automatic logic [COUNT_WIDTH-1:0] eff_stride(input logic [COUNT_WIDTH-1:0] s);
    if (s == {COUNT_WIDTH{1'b0}}) begin
      return {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      return s;
    end
  endfunction

  // Next index and terminal test; the extra bit keeps the carry visible to the compare.
  always_comb begin
    nxt_s      = {1'b0, count_r} + {1'b0, eff_stride(stride_r)};
    terminal_s = (nxt_s > {1'b0, max_r});
  end

  // Stride copy, reloaded together with max_r at sweep boundaries.
  always_ff @(posedge clk) begin
    if (load_cfg_s) begin
      stride_r <= bus.stride;
    end else begin
      stride_r <= stride_r;
    end
  end
`else
  // Unit step: the sweep ends exactly when the index reaches the limit.
  always_comb begin
    nxt_s      = {1'b0, count_r} + {{COUNT_WIDTH{1'b0}}, 1'b1};
    terminal_s = (count_r == max_r);
  end
`endif

  // Configuration reload points: reset, one-shot start, and every terminal step.
  always_comb begin
    load_cfg_s = 1'b0;
    if (sclr) begin
      load_cfg_s = 1'b1;
    end else if (state_r == ST_IDLE) begin
      load_cfg_s = bus.start;
    end else begin
      load_cfg_s = bus.en & terminal_s;
    end
  end

  // Limit copy; a live count_max change never disturbs the sweep in progress.
  always_ff @(posedge clk) begin
    if (load_cfg_s) begin
      max_r <= bus.count_max;
    end else begin
      max_r <= max_r;
    end
  end

  // Sweep sequencer with registered valid/wrap/done.
  always_ff @(posedge clk) begin
    if (sclr) begin
      count_r <= {COUNT_WIDTH{1'b0}};
      wrap_r  <= 1'b0;
      done_r  <= 1'b0;
      mode_r  <= bus.mode;
      state_r <= bus.mode ? ST_IDLE : ST_RUN;
      valid_r <= ~bus.mode;
    end else begin
      wrap_r <= 1'b0;
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          count_r <= {COUNT_WIDTH{1'b0}};
          if (bus.start) begin
            state_r <= ST_RUN;
            valid_r <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            valid_r <= 1'b0;
          end
        end
        ST_RUN: begin
          if (bus.en && terminal_s) begin
            count_r <= {COUNT_WIDTH{1'b0}};
            wrap_r  <= 1'b1;
            if (mode_r) begin
              state_r <= ST_IDLE;
              valid_r <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              state_r <= ST_RUN;
              valid_r <= 1'b1;
            end
          end else if (bus.en) begin
            count_r <= nxt_s[COUNT_WIDTH-1:0];
          end else begin
            count_r <= count_r;
          end
        end
        default: begin
          count_r <= {COUNT_WIDTH{1'b0}};
          state_r <= ST_IDLE;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.address = {count_r, {BYTE_SHIFT{1'b0}}};
  assign bus.valid   = valid_r;
  assign bus.wrap    = wrap_r;
  assign bus.done    = done_r;

endmodule

// File: doc/addr_gen_stride.md
# addr_gen_stride

Parametrised successor to the fixed-step BRAM address counter. It generates a byte address that steps by a programmable stride from 0 up to a programmable limit, once per enabled clock cycle. It runs either continuously (wrapping forever) or one-shot (a single sweep triggered by `start`). It sits between acquisition/playback control logic and BRAM port A, and flags sweep boundaries so that DMA and interrupt logic can track frames.

## Interface
- `COUNT_WIDTH`, 13, width of the word counter, `count_max` and `stride`.
- `BYTE_SHIFT`, 2, number of zero LSBs appended to form the byte address (2 gives 32-bit words).
- `clk`  in  1  single clock; all logic is on the rising edge.
- `sclr`  in  1  reset, synchronous and active-high.
- `en`  in  1  advance the counter this cycle while running.
- `mode`  in  1  0 = continuous, 1 = one-shot; sampled only while `sclr` = 1.
- `start`  in  1  one-shot trigger, honoured only in IDLE.
- `count_max`  in  COUNT_WIDTH  last permitted word index.
- `stride`  in  COUNT_WIDTH  word increment; 0 is treated as 1.
- `address`  out  COUNT_WIDTH+BYTE_SHIFT  `{count, BYTE_SHIFT'b0}`.
- `valid`  out  1  high while state = RUN.
- `wrap`  out  1  one-cycle pulse, coincident with the first address of a new sweep.
- `done`  out  1  one-cycle pulse when a one-shot sweep completes.

## Operation
- Registers:
  - `count` (COUNT_WIDTH)
  - `max_r` and `stride_r` (latched copies of `count_max` and `stride`)
  - `mode_r`
  - `state` (IDLE or RUN)
- `sclr` has priority over every other input. It sets:
  - `count` = 0, `wrap` = 0, `done` = 0;
  - `mode_r` ← `mode`, `max_r` ← `count_max`, `stride_r` ← `stride`;
  - `state` ← RUN if `mode` = 0, otherwise IDLE.
- Output values after reset:
  - `address` = 0, `wrap` = 0, `done` = 0;
  - `valid` = 1 in continuous mode, 0 in one-shot mode.
- IDLE (one-shot only):
  - `count` holds at 0 and `en` is ignored.
  - When `start` = 1: latch `max_r` and `stride_r`, then go to RUN.
- RUN, with `en` = 0: hold all registers.
- RUN, with `en` = 1:
  - Compute `nxt` = `count` + `stride_r` in COUNT_WIDTH+1 bits, so the carry is never lost.
  - If `nxt` > `max_r` (this includes `count` = `max_r`), the step is terminal:
    - `count` ← 0;
    - `max_r` and `stride_r` are re-latched from the live inputs;
    - `wrap` ← 1 for the next cycle.
    - If `mode_r` = 1, the state also goes to IDLE and `done` ← 1 for the next cycle.
  - Otherwise `count` ← `nxt[COUNT_WIDTH-1:0]`.
- Terminal-step rules:
  - The addresses visited are 0, s, 2s, … up to the largest multiple ≤ `max_r`. The counter never overshoots.
  - `count_max` = 0 makes every step terminal, so `address` stays 0 and `wrap` is high on every enabled cycle.
  - `count_max` = 2^COUNT_WIDTH−1 with `stride` = 1 wraps cleanly through the carry bit.
- Changes to `count_max`/`stride` take effect only at `sclr`, `start` or a terminal step, never in the middle of a sweep.
- `start` while in RUN is ignored.
- `sclr` during a sweep aborts it immediately; no `done` pulse is generated.

## Timing
- `address` is driven directly from the `count` register, with zero combinational logic from the inputs.
- Latency from an enabled step to the updated `address`: 1 cycle.
- `start` → first cycle with `valid` = 1 and `address` = 0: 1 cycle.
- `wrap` and `done` are registered pulses, exactly 1 cycle wide. They coincide with `address` = 0 after the terminal step.
  - One-shot: `done` and `wrap` are high in the same cycle, and `valid` goes low in that cycle.
- Back-to-back one-shot operation: `start` asserted in the cycle where `done` = 1 (state IDLE) begins a new sweep on the next cycle.

## Configuration
- `ADDR_GEN_STRIDE_EN`
  - Defined: stride logic as described above.
  - Undefined:
    - The `stride` input is ignored and `stride_r` is removed; the step is fixed at 1.
    - The terminal condition reduces to `count` == `max_r`.
    - All other behaviour is identical.

## Test plan
- Continuous, `count_max` = 3, `stride` = 1, `en` = 1 after `sclr` → `address` sequence 0,4,8,12,0,4…; `wrap` high only when `address` returns to 0.
- Continuous, `count_max` = 10, `stride` = 3 (`ADDR_GEN_STRIDE_EN` defined) → word index 0,3,6,9,0…; `address` 0,12,24,36,0.
- One-shot, `count_max` = 2, `start` pulse → `valid` high for 3 cycles with `address` 0,4,8. Then `done` = `wrap` = 1 with `valid` = 0, and `address` holds 0 while further `en` is applied.
- `en` toggled 1,0,0,1 with `count_max` = 7, `stride` = 1 → `address` 0→4, held at 4 for 2 cycles, then 8.
- `count_max` changed from 7 to 1 when the word index is 2 → sweep continues to 7, then subsequent sweeps are 0,1.
- `sclr` asserted mid one-shot at word index 5 → next cycle `address` = 0, `valid` = 0, `done` = 0; a new `start` restarts from 0.
